seq_shift_add_mult: RTL and testbench

//  Parametrised sequential shift-and-add multiplier: datapath plus its own control FSM.

---
 rtl/seq_shift_add_mult.sv | 105 ++++++++++
 tb/tb_seq_shift_add_mult.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier with its own IDLE/RUN/DONE controller.
// Operates on magnitudes and applies the sign at the end; optional early exit when RQ empties.
module seq_shift_add_mult #(
  parameter int W          = 8,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [W-1:0]     P,
  input  logic [W-1:0]     Q,
  output logic [2*W-1:0]   M,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [2*W-1:0]   r_a;
  logic [2*W-1:0]   r_rp;
  logic [W-1:0]     r_rq;
  logic             r_neg;
  logic [CW-1:0]    r_cnt;
  logic [2*W-1:0]   r_m;
  logic             r_done;

  logic [W-1:0]     w_p_mag;
  logic [W-1:0]     w_q_mag;
  logic             w_term;
  logic [2*W-1:0]   w_sum;
  logic [2*W-1:0]   w_result;

  // The most negative operand negates to 2^(W-1), which still fits W bits unsigned.
  assign w_p_mag  = (signed_mode && P[W-1]) ? (~P + W'(1)) : P;
  assign w_q_mag  = (signed_mode && Q[W-1]) ? (~Q + W'(1)) : Q;
  assign w_term   = (EARLY_TERM && (r_rq == '0)) || (r_cnt == CW'(W));
  assign w_sum    = r_a + (r_rq[0] ? r_rp : '0);
  assign w_result = r_neg ? (~r_a + (2*W)'(1)) : r_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_term) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_rp   <= '0;
      r_rq   <= '0;
      r_neg  <= 1'b0;
      r_cnt  <= '0;
      r_m    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= '0;
            r_rp  <= {{W{1'b0}}, w_p_mag};
            r_rq  <= w_q_mag;
            r_cnt <= '0;
            r_neg <= signed_mode & (P[W-1] ^ Q[W-1]);
          end
        end
        RUN: begin
          // done is registered here so it lines up with the DONE state cycle
          if (w_term) begin
            r_m    <= w_result;
            r_done <= 1'b1;
          end else begin
            r_a   <= w_sum;
            r_rp  <= r_rp << 1;
            r_rq  <= r_rq >> 1;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign M    = r_m;
  assign done = r_done;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: W=8 early-exit and full-run units share stimulus; a W=16 unit runs alone.
module tb_seq_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sm = 1'b0;
  logic [7:0]  P = '0;
  logic [7:0]  Q = '0;
  logic [15:0] M0, M1;
  logic        busy0, busy1, done0, done1;

  logic        start2 = 1'b0;
  logic        sm2 = 1'b0;
  logic [15:0] P2 = '0;
  logic [15:0] Q2 = '0;
  logic [31:0] M2;
  logic        busy2, done2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.W(8), .EARLY_TERM(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .P(P), .Q(Q),
    .M(M0), .busy(busy0), .done(done0));

  seq_shift_add_mult #(.W(8), .EARLY_TERM(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .P(P), .Q(Q),
    .M(M1), .busy(busy1), .done(done1));

  seq_shift_add_mult #(.W(16), .EARLY_TERM(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2), .P(P2), .Q(Q2),
    .M(M2), .busy(busy2), .done(done2));

  typedef struct {
    bit          sm;
    logic [7:0]  p;
    logic [7:0]  q;
    logic [15:0] m;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands' numeric values.
  function automatic longint val(input bit s, input int w, input logic [63:0] x);
    longint v;
    v = longint'(x & ((64'd1 << w) - 1));
    if (s && x[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic int bitlen(input longint m);
    int k = 0;
    while (m > 0) begin
      m = m >>> 1;
      k++;
    end
    return k;
  endfunction

  function automatic longint absv(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic do_op8(input bit s, input logic [7:0] p, input logic [7:0] q,
                        input logic [15:0] exp_m);
    int lat0 = -1, lat1 = -1, pul0 = 0, pul1 = 0, bsy0 = 0, bsy1 = 0, exp_lat0;
    logic [15:0] cap0 = 'x, cap1 = 'x;
    exp_lat0 = bitlen(absv(val(s, 8, 64'(q)))) + 2;
    @(negedge clk);
    start = 1'b1; sm = s; P = p; Q = q;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clk);
      else begin
        @(negedge clk);
        start = 1'b0; P = 8'($urandom); Q = 8'($urandom); sm = 1'($urandom);
      end
      if (busy0) bsy0++;
      if (busy1) bsy1++;
      if (done0) begin pul0++; if (lat0 < 0) begin lat0 = c; cap0 = M0; end end
      if (done1) begin pul1++; if (lat1 < 0) begin lat1 = c; cap1 = M1; end end
    end
    $display("op8 s=%0d %02h*%02h -> M0=%04h lat0=%0d M1=%04h lat1=%0d exp=%04h",
             s, p, q, cap0, lat0, cap1, lat1, exp_m);
    chk("m_early", 64'(cap0), 64'(exp_m));
    chk("m_full", 64'(cap1), 64'(exp_m));
    chk("lat_early", 64'(lat0), 64'(exp_lat0));
    chk("lat_full", 64'(lat1), 64'd10);
    chk("pulses_early", 64'(pul0), 64'd1);
    chk("pulses_full", 64'(pul1), 64'd1);
    chk("busy_early", 64'(bsy0), 64'(exp_lat0));
    chk("busy_full", 64'(bsy1), 64'd10);
  endtask

  task automatic do_op16(input bit s, input logic [15:0] p, input logic [15:0] q,
                         input logic [31:0] exp_m);
    int lat = -1, pul = 0;
    logic [31:0] cap = 'x;
    @(negedge clk);
    start2 = 1'b1; sm2 = s; P2 = p; Q2 = q;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start2 = 1'b0; P2 = 16'($urandom); Q2 = 16'($urandom);
      end
      if (done2) begin pul++; if (lat < 0) begin lat = c; cap = M2; end end
    end
    $display("op16 s=%0d %04h*%04h -> M=%08h lat=%0d exp=%08h", s, p, q, cap, lat, exp_m);
    chk("m16", 64'(cap), 64'(exp_m));
    chk("lat16", 64'(lat), 64'd18);
    chk("pulses16", 64'(pul), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 8'd13,  8'd11,  16'd143};
    tbl[1] = '{1'b0, 8'hFF,  8'h00,  16'h0000};
    tbl[2] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
    tbl[3] = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
    tbl[4] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    tbl[5] = '{1'b1, 8'h7F,  8'h80,  16'hC080};
    tbl[6] = '{1'b1, 8'hFF,  8'h00,  16'h0000};
    tbl[7] = '{1'b0, 8'h07,  8'h01,  16'h0007};
    tbl[8] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
    tbl[9] = '{1'b0, 8'h80,  8'h80,  16'h4000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m0", 64'(M0), 64'd0);
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_m2", 64'(M2), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_op8(tbl[i].sm, tbl[i].p, tbl[i].q, tbl[i].m);

    // start held high through RUN/DONE with new operands: only the IDLE-sampled start counts
    @(negedge clk);
    start = 1'b1; sm = 1'b0; P = 8'd13; Q = 8'd11;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) begin P = 8'd2; Q = 8'd3; end
      if (c == 6) begin chk("hold_done1", 64'(done0), 64'd1); chk("hold_m1", 64'(M0), 64'd143); end
      if (c == 7) begin chk("hold_idle", 64'(busy0), 64'd0); chk("hold_m_idle", 64'(M0), 64'd143); end
      if (c >= 8 && c <= 10) begin
        chk("hold_m_run", 64'(M0), 64'd143);
        chk("hold_nodone", 64'(done0), 64'd0);
      end
      if (c == 8) start = 1'b0;
      if (c == 11) begin chk("hold_done2", 64'(done0), 64'd1); chk("hold_m2", 64'(M0), 64'd6); end
    end
    $display("op8 held-start 13*11 then 2*3 -> M0=%04h", M0);
    repeat (20) @(negedge clk);

    // Reset in the middle of 255*255 aborts it
    @(negedge clk);
    start = 1'b1; sm = 1'b0; P = 8'hFF; Q = 8'hFF;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy0", 64'(busy0), 64'd0);
    chk("abort_m0", 64'(M0), 64'd0);
    chk("abort_busy1", 64'(busy1), 64'd0);
    chk("abort_m1", 64'(M1), 64'd0);
    begin
      int pulses = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (done0 || done1) pulses++;
      end
      chk("abort_nodone", 64'(pulses), 64'd0);
    end
    $display("op8 reset-abort 255*255 -> M0=%04h M1=%04h", M0, M1);
    do_op8(1'b0, 8'hFF, 8'hFF, 16'hFE01);

    // Randomised operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      bit s;
      logic [7:0] p, q;
      s = 1'($urandom);
      p = 8'($urandom);
      q = (i % 5 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      do_op8(s, p, q, 16'(val(s, 8, 64'(p)) * val(s, 8, 64'(q))));
    end

    do_op16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    do_op16(1'b1, 16'h8000, 16'h8000, 32'h40000000);
    for (int i = 0; i < 10; i++) begin
      bit s;
      logic [15:0] p, q;
      s = 1'($urandom);
      p = 16'($urandom);
      q = 16'($urandom);
      do_op16(s, p, q, 32'(val(s, 16, 64'(p)) * val(s, 16, 64'(q))));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
